// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam int COL_IDX_W = 2;   // width of the column index
  localparam int COL_W     = 4;   // one-cold column drive width
  localparam int ROW_W     = 4;   // active-low row input width
  localparam int CODE_W    = 4;   // key code: row_index*4 + col_index

  // Index of the lowest-numbered row pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [ROW_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_decoder.sv
// Combinational 2-to-4 active-low column decoder: exactly one output low.
module col_decoder_2to4
  import keypad_scanner_pkg::*;
(
  input  logic [COL_IDX_W-1:0] sel,
  output logic [COL_W-1:0]     col_n
);

  // Drive the selected column low, all others high.
  always_comb begin
    col_n      = '1;
    col_n[sel] = 1'b0;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row synchronizer, press/release debounce.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  row_n,
  output logic [COL_W-1:0]  col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_pressed
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ROW_W-1:0]     row_meta_q, row_meta_d;
  logic [ROW_W-1:0]     rows_q, rows_d;
  logic [DIV_W-1:0]     div_q, div_d;
  state_e               state_q, state_d;
  logic [COL_IDX_W-1:0] col_sel_q, col_sel_d;
  logic [CODE_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]     match_q, match_d;
  logic [CNT_W-1:0]     rel_q, rel_d;
  logic [CODE_W-1:0]    key_code_q, key_code_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_pressed_q, key_pressed_d;
  logic [COL_W-1:0]     col_n_q, col_dec;

  logic                 dwell_end;
  logic                 any_low;
  logic [CODE_W-1:0]    samp_code;
  logic                 cand_row_high;
  logic [CNT_W-1:0]     match_inc, rel_inc;

  // Decode the next column index so the registered drive lines up with col_sel_q.
  col_decoder_2to4 u_col_dec (
    .sel   (col_sel_d),
    .col_n (col_dec)
  );

  // Next-state logic: synchronizer shift, dwell timer and scan/debounce FSM.
  always_comb begin
    row_meta_d    = row_n;
    rows_d        = row_meta_q;
    dwell_end     = (div_q == DIV_LAST);
    div_d         = dwell_end ? '0 : div_q + DIV_W'(1);
    any_low       = (rows_q != '1);
    samp_code     = {lowest_low_row(rows_q), col_sel_q};
    cand_row_high = rows_q[cand_q[3:2]];
    match_inc     = match_q + CNT_ONE;
    rel_inc       = rel_q + CNT_ONE;

    state_d       = state_q;
    col_sel_d     = col_sel_q;
    cand_d        = cand_q;
    match_d       = match_q;
    rel_d         = rel_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;

    if (dwell_end) begin
      case (state_q)
        ST_SCAN: begin
          if (!any_low) begin
            col_sel_d = col_sel_q + 2'd1;
          end else begin
            // The capturing sample counts as the first match.
            cand_d = samp_code;
            if (DEBOUNCE_CNT <= 1) begin
              key_code_d    = samp_code;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              match_d       = '0;
              state_d       = ST_HELD;
            end else begin
              match_d = CNT_ONE;
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (any_low && (samp_code == cand_q)) begin
            if (match_inc == CNT_DONE) begin
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              match_d       = '0;
              state_d       = ST_HELD;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d   = '0;
            col_sel_d = col_sel_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Only the accepted key's row matters; other keys are ignored.
          if (cand_row_high) begin
            if (DEBOUNCE_CNT <= 1) begin
              key_pressed_d = 1'b0;
              col_sel_d     = col_sel_q + 2'd1;
              state_d       = ST_SCAN;
            end else begin
              rel_d   = CNT_ONE;
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (cand_row_high) begin
            if (rel_inc == CNT_DONE) begin
              rel_d         = '0;
              key_pressed_d = 1'b0;
              col_sel_d     = col_sel_q + 2'd1;
              state_d       = ST_SCAN;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d   = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // State and output registers; reset aborts any in-flight press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= '1;
      rows_q        <= '1;
      div_q         <= '0;
      state_q       <= ST_SCAN;
      col_sel_q     <= '0;
      cand_q        <= '0;
      match_q       <= '0;
      rel_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      col_n_q       <= 4'b1110;
    end else begin
      row_meta_q    <= row_meta_d;
      rows_q        <= rows_d;
      div_q         <= div_d;
      state_q       <= state_d;
      col_sel_q     <= col_sel_d;
      cand_q        <= cand_d;
      match_q       <= match_d;
      rel_q         <= rel_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      col_n_q       <= col_dec;
    end
  end

  assign col_n       = col_n_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, directed scenarios, random presses.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys = 16'h0000;   // bit r*4+c set = key at row r, column c held down

  int errors = 0;
  int checks = 0;

  // Reference model state (dwell-level abstraction)
  int   t;            // clock edges since reset release
  int   mcol;         // column being driven
  int   mode;         // 0 idle scan, 1 confirming, 2 held, 3 releasing
  int   cand;
  int   cnt;
  int   mcode;
  logic mvalid;
  logic mpressed;
  int   exp_pulses = 0;
  int   obs_pulses = 0;
  int   p0;

  always #5 clk = ~clk;

  // A pressed key connects its row to its column; a low column pulls that row low.
  function automatic logic [3:0] kp_rows(input logic [3:0] coln, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !coln[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] onecold(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  assign row_n = kp_rows(col_n, keys);

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; mcol = 0; mode = 0; cand = 0; cnt = 0; mcode = 0;
    mvalid = 1'b0; mpressed = 1'b0;
  endtask

  // One dwell-end decision from the keypad as seen on the model's column.
  task automatic model_dwell();
    logic [3:0] rows;
    int code;
    int low_row;
    rows = kp_rows(onecold(mcol), keys);
    low_row = 4;
    for (int i = 3; i >= 0; i--) if (!rows[i]) low_row = i;
    code = low_row * 4 + mcol;
    case (mode)
      0: begin
        if (low_row == 4) mcol = (mcol + 1) % 4;
        else begin cand = code; cnt = 1; mode = 1; end
      end
      1: begin
        if (low_row != 4 && code == cand) cnt++;
        else begin mode = 0; cnt = 0; mcol = (mcol + 1) % 4; end
      end
      2: begin
        if (rows[cand / 4]) begin cnt = 1; mode = 3; end
      end
      default: begin
        if (rows[cand / 4]) cnt++;
        else begin cnt = 0; mode = 2; end
      end
    endcase
    if (mode == 1 && cnt >= DC) begin
      mcode = cand; mvalid = 1'b1; mpressed = 1'b1; mode = 2; cnt = 0; exp_pulses++;
    end
    if (mode == 3 && cnt >= DC) begin
      mpressed = 1'b0; mcol = (mcol + 1) % 4; mode = 0; cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    mvalid = 1'b0;
    if (t % SD == 0) model_dwell();
    if (key_valid === 1'b1) obs_pulses++;
    chk("col_n", 32'(col_n), 32'(onecold(mcol)));
    chk("key_valid", 32'(key_valid), 32'(mvalid));
    chk("key_pressed", 32'(key_pressed), 32'(mpressed));
    chk("key_code", 32'(key_code), 32'(mcode));
  endtask

  task automatic run_dwells(input int n);
    repeat (n * SD) tick();
  endtask

  // Advance idle scanning until the model drives column c (bounded).
  task automatic wait_col(input int c);
    int guard;
    guard = 0;
    while (mcol != c && guard < 8) begin
      run_dwells(1);
      guard++;
    end
    chk("wait_col_reached", 32'(mcol), 32'(c));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_n"}, 32'(col_n), 32'h0000000E);
    chk({tag, "_key_code"}, 32'(key_code), 32'h0);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_key_pressed"}, 32'(key_pressed), 32'h0);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle scan: five dwells, wrapping through all columns
    run_dwells(5);
    chk("idle_no_valid", 32'(obs_pulses), 32'h0);

    // Press row 2 on column 1 -> code 9, then release
    keys = 16'h0001 << 9;
    p0 = obs_pulses;
    run_dwells(3);
    chk("press_pulses", 32'(obs_pulses - p0), 32'h1);
    chk("press_code", 32'(key_code), 32'h9);
    chk("press_held", 32'(key_pressed), 32'h1);
    chk("press_col_frozen", 32'(col_n), 32'hD);
    keys = 16'h0000;
    run_dwells(1);
    chk("release_after1", 32'(key_pressed), 32'h1);
    run_dwells(1);
    chk("release_after2", 32'(key_pressed), 32'h0);
    chk("release_resume_col", 32'(col_n), 32'hB);

    // Bounce: row 0 low for a single dwell
    wait_col(0);
    keys = 16'h0001;
    p0 = obs_pulses;
    run_dwells(1);
    keys = 16'h0000;
    run_dwells(1);
    chk("bounce_no_valid", 32'(obs_pulses - p0), 32'h0);
    chk("bounce_not_held", 32'(key_pressed), 32'h0);
    chk("bounce_col_advance", 32'(col_n), 32'hD);

    // Multi-key: rows 1 and 3 on column 0 -> lowest row wins
    wait_col(0);
    keys = (16'h0001 << 4) | (16'h0001 << 12);
    run_dwells(3);
    chk("multi_code", 32'(key_code), 32'h4);
    chk("multi_held", 32'(key_pressed), 32'h1);
    keys = 16'h0000;
    run_dwells(2);
    chk("multi_released", 32'(key_pressed), 32'h0);

    // Release glitch: one high dwell while held
    wait_col(2);
    keys = 16'h0001 << 6;
    run_dwells(3);
    p0 = obs_pulses;
    keys = 16'h0000;
    run_dwells(1);
    keys = 16'h0001 << 6;
    run_dwells(2);
    chk("glitch_no_pulse", 32'(obs_pulses - p0), 32'h0);
    chk("glitch_held", 32'(key_pressed), 32'h1);
    chk("glitch_code", 32'(key_code), 32'h6);
    keys = 16'h0000;
    run_dwells(2);

    // Reset while held, then the same key yields exactly one new pulse
    wait_col(3);
    keys = 16'h0001 << 3;
    run_dwells(3);
    chk("pre_reset_held", 32'(key_pressed), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    p0 = obs_pulses;
    run_dwells(6);
    chk("after_reset_pulses", 32'(obs_pulses - p0), 32'h1);
    chk("after_reset_code", 32'(key_code), 32'h3);
    keys = 16'h0000;
    run_dwells(2);

    // Random key activity checked against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       keys = 16'h0000;
        1, 2:    keys = 16'h0001 << $urandom_range(0, 15);
        default: keys = 16'($urandom);
      endcase
      run_dwells($urandom_range(1, 6));
    end
    chk("pulse_total", 32'(obs_pulses), 32'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
